pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 132 +++++++++++++
 tb/tb_pc_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program counter with branch resolution, link capture,
//             misaligned-target fault handling and a taken-branch counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    OFFSET_WIDTH = 26,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    fetchReady,
  input  logic                    resolveValid,
  input  logic                    branchFlag,
  input  logic                    unconditionalBranchFlag,
  input  logic                    registerBranchFlag,
  input  logic                    linkFlag,
  input  logic                    zeroFlag,
  input  logic                    invertZero,
  input  logic [ADDR_WIDTH-1:0]   branchPc,
  input  logic [OFFSET_WIDTH-1:0] pcOffset,
  input  logic [ADDR_WIDTH-1:0]   registerTarget,
  input  logic                    faultClear,
  output logic [ADDR_WIDTH-1:0]   PC,
  output logic                    pcValid,
  output logic                    redirect,
  output logic [ADDR_WIDTH-1:0]   linkAddress,
  output logic                    alignFault,
  output logic [31:0]             takenCount
);

  // Sign extension happens at a width wide enough for both the shifted
  // offset and the address, then truncates so arithmetic wraps mod 2^ADDR_WIDTH.
  localparam int c_EXT_WIDTH = (ADDR_WIDTH > OFFSET_WIDTH + 2) ? ADDR_WIDTH : OFFSET_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] c_FOUR = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_pcNext;
  logic                    r_redirect;
  logic                    w_redirectNext;
  logic [ADDR_WIDTH-1:0]   r_linkAddress;
  logic                    w_linkLoad;
  logic [31:0]             r_takenCount;
  logic                    w_countInc;

  logic [c_EXT_WIDTH-1:0]  w_offsetExt;
  logic [ADDR_WIDTH-1:0]   w_relTarget;
  logic [ADDR_WIDTH-1:0]   w_target;
  logic                    w_taken;
  logic                    w_aligned;

  assign w_offsetExt = {{(c_EXT_WIDTH - OFFSET_WIDTH){pcOffset[OFFSET_WIDTH-1]}}, pcOffset} << 2;
  assign w_relTarget = branchPc + w_offsetExt[ADDR_WIDTH-1:0];
  assign w_target    = registerBranchFlag ? registerTarget : w_relTarget;
  assign w_aligned   = (w_target[1:0] == 2'b00);
  assign w_taken     = resolveValid &
                       (registerBranchFlag | unconditionalBranchFlag |
                        (branchFlag & (zeroFlag ^ invertZero)));

  always_comb begin
    w_nextState    = r_state;
    w_pcNext       = r_pc;
    w_redirectNext = 1'b0;
    w_linkLoad     = 1'b0;
    w_countInc     = 1'b0;
    case (r_state)
      INIT: w_nextState = RUN;
      RUN: begin
        w_linkLoad = resolveValid & linkFlag;
        if (w_taken) begin
          if (w_aligned) begin
            w_pcNext       = w_target;
            w_redirectNext = 1'b1;
            w_countInc     = 1'b1;
          end else begin
            w_nextState = FAULT;
          end
        end else if (fetchReady) begin
          w_pcNext = r_pc + c_FOUR;
        end
      end
      FAULT: begin
        if (faultClear) begin
          w_pcNext    = RESET_VECTOR;
          w_nextState = INIT;
        end
      end
      default: w_nextState = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state       <= INIT;
      r_pc          <= RESET_VECTOR;
      r_redirect    <= 1'b0;
      r_linkAddress <= '0;
      r_takenCount  <= '0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_pcNext;
      r_redirect <= w_redirectNext;
      if (w_linkLoad) begin
        r_linkAddress <= branchPc + c_FOUR;
      end
      // Counter saturates rather than wrapping.
      if (w_countInc && (r_takenCount != 32'hFFFF_FFFF)) begin
        r_takenCount <= r_takenCount + 32'd1;
      end
    end
  end

  assign PC          = r_pc;
  assign pcValid     = (r_state == RUN);
  assign alignFault  = (r_state == FAULT);
  assign redirect    = r_redirect;
  assign linkAddress = r_linkAddress;
  assign takenCount  = r_takenCount;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit (64-bit and 8-bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clock;
  logic        resetN;
  logic        fetchReady;
  logic        resolveValid;
  logic        branchFlag;
  logic        unconditionalBranchFlag;
  logic        registerBranchFlag;
  logic        linkFlag;
  logic        zeroFlag;
  logic        invertZero;
  logic [63:0] branchPc;
  logic [25:0] pcOffset;
  logic [63:0] registerTarget;
  logic        faultClear;

  logic [63:0] PC;
  logic        pcValid;
  logic        redirect;
  logic [63:0] linkAddress;
  logic        alignFault;
  logic [31:0] takenCount;

  logic [7:0]  pc8;
  logic        pcValid8;
  logic        redirect8;
  logic [7:0]  linkAddress8;
  logic        alignFault8;
  logic [31:0] takenCount8;

  int vectors     = 0;
  int miscompares = 0;

  pc_unit u_dut (
    .clock                   (clock),
    .resetN                  (resetN),
    .fetchReady              (fetchReady),
    .resolveValid            (resolveValid),
    .branchFlag              (branchFlag),
    .unconditionalBranchFlag (unconditionalBranchFlag),
    .registerBranchFlag      (registerBranchFlag),
    .linkFlag                (linkFlag),
    .zeroFlag                (zeroFlag),
    .invertZero              (invertZero),
    .branchPc                (branchPc),
    .pcOffset                (pcOffset),
    .registerTarget          (registerTarget),
    .faultClear              (faultClear),
    .PC                      (PC),
    .pcValid                 (pcValid),
    .redirect                (redirect),
    .linkAddress             (linkAddress),
    .alignFault              (alignFault),
    .takenCount              (takenCount)
  );

  pc_unit #(
    .ADDR_WIDTH   (8),
    .OFFSET_WIDTH (26),
    .RESET_VECTOR (8'hF8)
  ) u_dut8 (
    .clock                   (clock),
    .resetN                  (resetN),
    .fetchReady              (fetchReady),
    .resolveValid            (resolveValid),
    .branchFlag              (branchFlag),
    .unconditionalBranchFlag (unconditionalBranchFlag),
    .registerBranchFlag      (registerBranchFlag),
    .linkFlag                (linkFlag),
    .zeroFlag                (zeroFlag),
    .invertZero              (invertZero),
    .branchPc                (branchPc[7:0]),
    .pcOffset                (pcOffset),
    .registerTarget          (registerTarget[7:0]),
    .faultClear              (faultClear),
    .PC                      (pc8),
    .pcValid                 (pcValid8),
    .redirect                (redirect8),
    .linkAddress             (linkAddress8),
    .alignFault              (alignFault8),
    .takenCount              (takenCount8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    fetchReady              = 1'b0;
    resolveValid            = 1'b0;
    branchFlag              = 1'b0;
    unconditionalBranchFlag = 1'b0;
    registerBranchFlag      = 1'b0;
    linkFlag                = 1'b0;
    zeroFlag                = 1'b0;
    invertZero              = 1'b0;
    branchPc                = '0;
    pcOffset                = '0;
    registerTarget          = '0;
    faultClear              = 1'b0;
  endtask

  initial begin
    clearInputs();
    resetN = 1'b0;
    step();
    step();
    check("rst_pc", PC, 64'h0);
    check("rst_pcValid", {63'd0, pcValid}, 64'd0);
    check("rst_redirect", {63'd0, redirect}, 64'd0);
    check("rst_alignFault", {63'd0, alignFault}, 64'd0);
    check("rst_takenCount", {32'd0, takenCount}, 64'd0);
    check("rst_link", linkAddress, 64'h0);

    resetN = 1'b1;
    step();
    step();
    check("run_pcValid", {63'd0, pcValid}, 64'd1);
    check("run_pc0", PC, 64'h0);

    fetchReady = 1'b1;
    step(); check("seq_pc4", PC, 64'h4);
    step(); check("seq_pc8", PC, 64'h8);
    step(); check("seq_pcC", PC, 64'hC);
    check("seq_redirect", {63'd0, redirect}, 64'd0);
    repeat (61) step();
    check("seq_pc100", PC, 64'h100);

    // Conditional branch on zero, backwards by two words.
    resolveValid = 1'b1; branchFlag = 1'b1; zeroFlag = 1'b1;
    branchPc = 64'hF8; pcOffset = 26'h3FF_FFFE;
    step();
    check("beq_pc", PC, 64'hF0);
    check("beq_redirect", {63'd0, redirect}, 64'd1);
    check("beq_count", {32'd0, takenCount}, 64'd1);
    clearInputs();
    step();
    check("beq_pulse_end", {63'd0, redirect}, 64'd0);
    check("beq_hold", PC, 64'hF0);

    fetchReady = 1'b1;
    repeat (4) step();
    check("back_to_100", PC, 64'h100);
    resolveValid = 1'b1; branchFlag = 1'b1; zeroFlag = 1'b1; invertZero = 1'b1;
    branchPc = 64'hF8; pcOffset = 26'h3FF_FFFE;
    step();
    check("bne_pc", PC, 64'h104);
    check("bne_redirect", {63'd0, redirect}, 64'd0);
    check("bne_count", {32'd0, takenCount}, 64'd1);

    clearInputs();
    resolveValid = 1'b1; unconditionalBranchFlag = 1'b1;
    branchPc = 64'h104; pcOffset = 26'd4;
    step();
    check("b2b1_pc", PC, 64'h114);
    check("b2b1_redirect", {63'd0, redirect}, 64'd1);
    check("b2b1_count", {32'd0, takenCount}, 64'd2);
    branchPc = 64'h114; pcOffset = 26'h3FF_FFFF;
    step();
    check("b2b2_pc", PC, 64'h110);
    check("b2b2_redirect", {63'd0, redirect}, 64'd1);
    check("b2b2_count", {32'd0, takenCount}, 64'd3);
    clearInputs();
    step();
    check("b2b_end", {63'd0, redirect}, 64'd0);

    // Register target takes priority over relative and conditional paths.
    resolveValid = 1'b1; registerBranchFlag = 1'b1; linkFlag = 1'b1;
    branchFlag = 1'b1; zeroFlag = 1'b1; pcOffset = 26'd100;
    branchPc = 64'h110; registerTarget = 64'h400;
    step();
    check("br_pc", PC, 64'h400);
    check("br_link", linkAddress, 64'h114);
    check("br_count", {32'd0, takenCount}, 64'd4);
    check("br_redirect", {63'd0, redirect}, 64'd1);

    clearInputs();
    resolveValid = 1'b1; registerBranchFlag = 1'b1; linkFlag = 1'b1;
    branchPc = 64'h200; registerTarget = 64'h1002;
    step();
    check("flt_alignFault", {63'd0, alignFault}, 64'd1);
    check("flt_pcValid", {63'd0, pcValid}, 64'd0);
    check("flt_link", linkAddress, 64'h204);
    check("flt_pc_hold", PC, 64'h400);
    check("flt_count", {32'd0, takenCount}, 64'd4);
    check("flt_redirect", {63'd0, redirect}, 64'd0);

    clearInputs();
    resolveValid = 1'b1; unconditionalBranchFlag = 1'b1; linkFlag = 1'b1;
    branchPc = 64'h300; fetchReady = 1'b1;
    step();
    check("flt_ignore_pc", PC, 64'h400);
    check("flt_ignore_link", linkAddress, 64'h204);
    check("flt_ignore_count", {32'd0, takenCount}, 64'd4);
    check("flt_stays", {63'd0, alignFault}, 64'd1);

    clearInputs();
    faultClear = 1'b1;
    step();
    check("clr_pc", PC, 64'h0);
    check("clr_init_pcValid", {63'd0, pcValid}, 64'd0);
    check("clr_alignFault", {63'd0, alignFault}, 64'd0);
    faultClear = 1'b0;
    step();
    check("clr_run_pcValid", {63'd0, pcValid}, 64'd1);

    resolveValid = 1'b1; branchFlag = 1'b1; zeroFlag = 1'b0;
    pcOffset = 26'd8;
    step();
    check("nt_pc", PC, 64'h0);
    check("nt_redirect", {63'd0, redirect}, 64'd0);

    // Reset during a taken-branch cycle.
    clearInputs();
    resolveValid = 1'b1; unconditionalBranchFlag = 1'b1; pcOffset = 26'd8;
    resetN = 1'b0;
    step();
    check("rstbr_pc", PC, 64'h0);
    check("rstbr_redirect", {63'd0, redirect}, 64'd0);
    check("rstbr_count", {32'd0, takenCount}, 64'd0);
    check("rstbr_link", linkAddress, 64'h0);
    check("rstbr_pcValid", {63'd0, pcValid}, 64'd0);

    // 8-bit instance: wrap-around of sequential and relative addressing.
    clearInputs();
    resetN = 1'b1;
    step();
    step();
    check("w8_pc_reset", {56'd0, pc8}, 64'hF8);
    check("w8_pcValid", {63'd0, pcValid8}, 64'd1);
    fetchReady = 1'b1;
    step(); check("w8_pcFC", {56'd0, pc8}, 64'hFC);
    step(); check("w8_wrap", {56'd0, pc8}, 64'h00);
    fetchReady = 1'b0;
    resolveValid = 1'b1; unconditionalBranchFlag = 1'b1;
    branchPc = 64'hFC; pcOffset = 26'd1;
    step();
    check("w8_br_pc", {56'd0, pc8}, 64'h00);
    check("w8_br_redirect", {63'd0, redirect8}, 64'd1);
    branchPc = 64'h04; pcOffset = 26'h3FF_FFFC;
    step();
    check("w8_neg_pc", {56'd0, pc8}, 64'hF4);
    check("w8_count", {32'd0, takenCount8}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
